alu_accumulator: RTL and testbench



---
 rtl/alu_if.sv | 22 ++
 rtl/alu_accumulator.sv | 120 ++++++++++++
 tb/tb_alu_accumulator.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Operand/opcode bus into the registered ALU, plus its registered result and status.
// The master drives operands and opcode; the slave (the ALU) returns result and error code.
interface alu_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic [WIDTH-1:0] inputP;
  logic [WIDTH-1:0] inputQ;
  logic [OPW-1:0]   opCode;
  logic [WIDTH-1:0] outALU;
  logic [1:0]       errorCode;

  modport master (
    output inputP, inputQ, opCode,
    input  outALU, errorCode
  );

  modport slave (
    input  inputP, inputQ, opCode,
    output outALU, errorCode
  );
endinterface

// File: rtl/alu_accumulator.sv
// Registered unsigned ALU: combinational compute of the selected opcode, one register stage
// holding the result and a 2-bit status that is rewritten on every clock edge.
module alu_accumulator #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  typedef enum logic [OPW-1:0] {
    OP_NOOP   = 4'b0000,
    OP_ADD    = 4'b0001,
    OP_SUB    = 4'b0010,
    OP_MUL    = 4'b0011,
    OP_DIV    = 4'b0100,
    OP_MOD    = 4'b0101,
    OP_AND    = 4'b0110,
    OP_OR     = 4'b0111,
    OP_XOR    = 4'b1000,
    OP_NOT    = 4'b1001,
    OP_NAND   = 4'b1010,
    OP_NOR    = 4'b1011,
    OP_CLEAR  = 4'b1100,
    OP_PRESET = 4'b1101,
    OP_XNOR   = 4'b1110
  } aluOpT;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_OVERFLOW = 2'b01,
    ERR_DIVZERO  = 2'b10,
    ERR_BADOP    = 2'b11
  } errCodeT;

  aluOpT              op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH:0]     sumWide;
  logic [2*WIDTH-1:0] productWide;
  logic               divByZero;

  logic [WIDTH-1:0]   resultQ;
  errCodeT            errorQ;
  logic [WIDTH-1:0]   nextResult;
  errCodeT            nextError;

  assign op          = aluOpT'(bus.opCode);
  assign a           = bus.inputP;
  assign b           = bus.inputQ;
  assign sumWide     = {1'b0, a} + {1'b0, b};
  assign productWide = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign divByZero   = (b == '0);

  // NOTE: every output of this block is given a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    nextResult = resultQ;
    nextError  = ERR_OK;
    case (op)
      OP_NOOP: ;
      OP_ADD: begin
        nextResult = sumWide[WIDTH-1:0];
        if (sumWide[WIDTH]) nextError = ERR_OVERFLOW;
      end
      OP_SUB: begin
        nextResult = a - b;
        if (a < b) nextError = ERR_OVERFLOW;
      end
      OP_MUL: begin
        nextResult = productWide[WIDTH-1:0];
        if (productWide[2*WIDTH-1:WIDTH] != '0) nextError = ERR_OVERFLOW;
      end
      OP_DIV: begin
        if (divByZero) begin
          nextResult = '0;
          nextError  = ERR_DIVZERO;
        end else begin
          nextResult = a / b;
        end
      end
      OP_MOD: begin
        if (divByZero) begin
          nextResult = '0;
          nextError  = ERR_DIVZERO;
        end else begin
          nextResult = a % b;
        end
      end
      OP_AND:    nextResult = a & b;
      OP_OR:     nextResult = a | b;
      OP_XOR:    nextResult = a ^ b;
      OP_NOT:    nextResult = ~a;
      OP_NAND:   nextResult = ~(a & b);
      OP_NOR:    nextResult = ~(a | b);
      OP_XNOR:   nextResult = ~(a ^ b);
      OP_CLEAR:  nextResult = '0;
      OP_PRESET: nextResult = '1;
      // 1111 and any unknown opcode: keep the previous result, flag a bad opcode.
      default:   nextError  = ERR_BADOP;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resultQ <= '0;
      errorQ  <= ERR_OK;
    end else begin
      resultQ <= nextResult;
      errorQ  <= nextError;
    end
  end

  assign bus.outALU    = resultQ;
  assign bus.errorCode = errorQ;

endmodule

// File: tb/tb_alu_accumulator.sv
// Scoreboard bench for alu_accumulator: stimulus pushes expected results, a monitor pops
// and compares one cycle later; random operations are scored against a 64-bit reference model.
module tb_alu_accumulator;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] res;
    logic [1:0]  err;
  } expT;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passed = 0;
  expT  scoreboard[$];
  logic [31:0] modelAcc;

  alu_if #(.WIDTH(32), .OPW(4)) bus ();

  alu_accumulator #(.WIDTH(32), .OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required)
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, required, $time);
    else
      passed++;
  endtask

  // Reference model: operations evaluated with 64-bit integer arithmetic and compared
  // against the 32-bit range to decide overflow.
  function automatic expT refModel(input logic [3:0] op, input logic [31:0] p,
                                   input logic [31:0] q, input logic [31:0] acc);
    longint unsigned wp  = {32'd0, p};
    longint unsigned wq  = {32'd0, q};
    longint unsigned big = 0;
    expT e;
    e.op  = op;
    e.res = acc;
    e.err = 2'd0;
    case (op)
      4'd0:  ;
      4'd1:  begin big = wp + wq; e.res = big[31:0]; if (big > 64'hFFFF_FFFF) e.err = 2'd1; end
      4'd2:  begin e.res = p - q; if (p < q) e.err = 2'd1; end
      4'd3:  begin big = wp * wq; e.res = big[31:0]; if (big > 64'hFFFF_FFFF) e.err = 2'd1; end
      4'd4:  if (q == 0) begin e.res = 0; e.err = 2'd2; end else e.res = p / q;
      4'd5:  if (q == 0) begin e.res = 0; e.err = 2'd2; end else e.res = p % q;
      4'd6:  e.res = p & q;
      4'd7:  e.res = p | q;
      4'd8:  e.res = p ^ q;
      4'd9:  e.res = ~p;
      4'd10: e.res = ~(p & q);
      4'd11: e.res = ~(p | q);
      4'd12: e.res = 32'd0;
      4'd13: e.res = 32'hFFFF_FFFF;
      4'd14: e.res = ~(p ^ q);
      default: e.err = 2'd3;
    endcase
    return e;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] p, input logic [31:0] q);
    bus.opCode = op;
    bus.inputP = p;
    bus.inputQ = q;
  endtask

  // Directed operation with the expected result written out by hand.
  task automatic directed(input logic [3:0] op, input logic [31:0] p, input logic [31:0] q,
                          input logic [31:0] expRes, input logic [1:0] expErr);
    @(negedge clk);
    drive(op, p, q);
    scoreboard.push_back('{op: op, res: expRes, err: expErr});
    modelAcc = expRes;
    @(posedge clk);
  endtask

  task automatic modelled(input logic [3:0] op, input logic [31:0] p, input logic [31:0] q);
    expT e;
    @(negedge clk);
    drive(op, p, q);
    e = refModel(op, p, q, modelAcc);
    modelAcc = e.res;
    scoreboard.push_back(e);
    @(posedge clk);
  endtask

  // Asserts rst between edges with a live ADD on the bus: the outputs must clear at once
  // and stay cleared across an edge while rst is held.
  task automatic resetPulse();
    @(negedge clk);
    drive(4'd1, 32'd5, 32'd7);
    rst = 1'b1;
    #1;
    check("async_reset_result", bus.outALU, 32'd0);
    check("async_reset_error", {30'd0, bus.errorCode}, 32'd0);
    @(posedge clk);
    #2;
    check("reset_held_result", bus.outALU, 32'd0);
    check("reset_held_error", {30'd0, bus.errorCode}, 32'd0);
    @(negedge clk);
    drive(4'd0, 32'd0, 32'd0);
    rst = 1'b0;
    modelAcc = 32'd0;
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: the DUT presents a new result after every rising edge.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (scoreboard.size() != 0) begin
        e = scoreboard.pop_front();
        check($sformatf("op%0d_result", e.op), bus.outALU, e.res);
        check($sformatf("op%0d_error", e.op), {30'd0, bus.errorCode}, {30'd0, e.err});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b0;
    modelAcc = 32'd0;
    drive(4'd0, 32'd0, 32'd0);

    #3 rst = 1'b1;
    #1;
    check("initial_async_reset_result", bus.outALU, 32'd0);
    check("initial_async_reset_error", {30'd0, bus.errorCode}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    directed(4'b0000, 32'd0, 32'd0, 32'd0, 2'b00);
    directed(4'b1100, 32'd11, 32'd22, 32'd0, 2'b00);
    directed(4'b0011, 32'd3000, 32'd20617524, 32'd1723029856, 2'b01);
    directed(4'b0001, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'b01);
    directed(4'b0001, 32'd5, 32'd7, 32'd12, 2'b00);
    directed(4'b0100, 32'd100, 32'd7, 32'd14, 2'b00);
    directed(4'b0101, 32'd100, 32'd7, 32'd2, 2'b00);
    directed(4'b0100, 32'd9, 32'd0, 32'd0, 2'b10);
    directed(4'b0101, 32'd9, 32'd0, 32'd0, 2'b10);
    directed(4'b0010, 32'd3, 32'd5, 32'hFFFF_FFFE, 2'b01);
    directed(4'b1000, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 2'b00);
    directed(4'b1101, 32'd0, 32'd0, 32'hFFFF_FFFF, 2'b00);
    directed(4'b1111, 32'd1, 32'd2, 32'hFFFF_FFFF, 2'b11);
    directed(4'b0000, 32'd1, 32'd2, 32'hFFFF_FFFF, 2'b00);
    resetPulse();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) resetPulse();
      modelled(4'($urandom_range(0, 15)), pickOperand(), pickOperand());
    end

    @(negedge clk);
    check("scoreboard_drained", 32'(scoreboard.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
